// File: rtl/systolic_job_arbiter.sv
// Round-robin arbiter sharing one NxN systolic-array multiplier between M requesters, one job in flight.
// Optional watchdog on the result wait is enabled by defining SYSTOLIC_ARB_WATCHDOG_EN.
module systolic_job_arbiter #(
  parameter int N       = 4,
  parameter int M       = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                               i_clk,
  input  logic                               i_arst,
  input  logic [M-1:0]                       i_reqValid,
  output logic [M-1:0]                       o_reqReady,
  input  logic [M*N*N*8-1:0]                 i_reqA,
  input  logic [M*N*N*8-1:0]                 i_reqB,
  output logic [M-1:0]                       o_rspValid,
  input  logic [M-1:0]                       i_rspReady,
  output logic [N*N*32-1:0]                  o_rspC,
  output logic                               o_rspErr,
  output logic [N*N*8-1:0]                   o_saA,
  output logic [N*N*8-1:0]                   o_saB,
  output logic                               o_saValidInput,
  input  logic [N*N*32-1:0]                  i_saC,
  input  logic                               i_saValidResult,
  output logic                               o_busy,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] o_owner
);

  localparam int OW = (M > 1) ? $clog2(M) : 1;
  localparam int EW = N * N * 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg;
  logic [OW-1:0]    ptr_reg;
  logic [OW-1:0]    owner_reg;
  logic [EW-1:0]    sa_a_reg;
  logic [EW-1:0]    sa_b_reg;
  logic             sa_valid_reg;
  logic [N*N*32-1:0] rsp_c_reg;

  logic             grant_found;
  logic [OW-1:0]    grant_idx;
  logic [OW-1:0]    scan_idx;

  // Scan downward so the candidate closest to ptr+1 is the last (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = M; i >= 1; i--) begin
      scan_idx = OW'((int'(ptr_reg) + i) % M);
      if (i_reqValid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    o_reqReady = '0;
    if (state_reg == IDLE && grant_found)
      o_reqReady[grant_idx] = 1'b1;
  end

  always_comb begin
    o_rspValid = '0;
    if (state_reg == RESP)
      o_rspValid[owner_reg] = 1'b1;
  end

`ifdef SYSTOLIC_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  logic [WD_W-1:0] wd_cnt_reg;
  logic            rsp_err_reg;
  assign o_rspErr = rsp_err_reg;
`else
  assign o_rspErr = 1'b0;
  // TIMEOUT is only consumed by the watchdog build.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_reg    <= IDLE;
      ptr_reg      <= OW'(M - 1);
      owner_reg    <= '0;
      sa_a_reg     <= '0;
      sa_b_reg     <= '0;
      sa_valid_reg <= 1'b0;
      rsp_c_reg    <= '0;
`ifdef SYSTOLIC_ARB_WATCHDOG_EN
      wd_cnt_reg   <= '0;
      rsp_err_reg  <= 1'b0;
`endif
    end else begin
      sa_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            sa_a_reg     <= i_reqA[grant_idx*EW +: EW];
            sa_b_reg     <= i_reqB[grant_idx*EW +: EW];
            owner_reg    <= grant_idx;
            sa_valid_reg <= 1'b1;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SYSTOLIC_ARB_WATCHDOG_EN
          wd_cnt_reg <= '0;
`endif
          state_reg <= WAIT;
        end
        WAIT: begin
          if (i_saValidResult) begin
            rsp_c_reg <= i_saC;
`ifdef SYSTOLIC_ARB_WATCHDOG_EN
            rsp_err_reg <= 1'b0;
`endif
            state_reg <= RESP;
          end
`ifdef SYSTOLIC_ARB_WATCHDOG_EN
          else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
            rsp_c_reg   <= '0;
            rsp_err_reg <= 1'b1;
            state_reg   <= RESP;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
`endif
        end
        RESP: begin
          if (i_rspReady[owner_reg]) begin
            ptr_reg   <= owner_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_saA          = sa_a_reg;
  assign o_saB          = sa_b_reg;
  assign o_saValidInput = sa_valid_reg;
  assign o_rspC         = rsp_c_reg;
  assign o_owner        = owner_reg;
  assign o_busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Directed bench for systolic_job_arbiter; a 5-cycle array stub returns C = A*B.
module tb_systolic_job_arbiter;
  localparam int N = 4;
  localparam int M = 2;
  localparam int EW = N * N * 8;
  localparam int CW = N * N * 32;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [M-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [M*EW-1:0] req_a = '0, req_b = '0;
  logic [CW-1:0] rsp_c, sa_c;
  logic rsp_err, sa_valid, sa_res, busy;
  logic [EW-1:0] sa_a, sa_b;
  logic owner;

  int tests = 0;
  int fails = 0;

  bit stub_en = 1'b1;
  bit force_pulse = 1'b0;
  logic [2:0] stub_cnt;
  logic stub_res;
  logic [CW-1:0] stub_c;
  logic [CW-1:0] junk_c;

  always #5 clk = ~clk;

  systolic_job_arbiter #(.N(N), .M(M), .TIMEOUT(31)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_reqValid(req_valid), .o_reqReady(req_ready),
    .i_reqA(req_a), .i_reqB(req_b),
    .o_rspValid(rsp_valid), .i_rspReady(rsp_ready),
    .o_rspC(rsp_c), .o_rspErr(rsp_err),
    .o_saA(sa_a), .o_saB(sa_b), .o_saValidInput(sa_valid),
    .i_saC(sa_c), .i_saValidResult(sa_res),
    .o_busy(busy), .o_owner(owner)
  );

  function automatic logic [EW-1:0] ident8(input int s);
    logic [EW-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*8 +: 8] = 8'(s);
    return m;
  endfunction

  function automatic logic [EW-1:0] fill8(input int v);
    logic [EW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*8 +: 8] = 8'(v);
    return m;
  endfunction

  function automatic logic [CW-1:0] fill32(input int v);
    logic [CW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*32 +: 32] = 32'(v);
    return m;
  endfunction

  function automatic logic [CW-1:0] matmul(input logic [EW-1:0] a, input logic [EW-1:0] b);
    logic [CW-1:0] c;
    logic [31:0] acc;
    for (int r = 0; r < N; r++)
      for (int col = 0; col < N; col++) begin
        acc = '0;
        for (int k = 0; k < N; k++)
          acc = acc + 32'(a[(r*N+k)*8 +: 8]) * 32'(b[(k*N+col)*8 +: 8]);
        c[(r*N+col)*32 +: 32] = acc;
      end
    return c;
  endfunction

  // Array stub: result pulse lands 5 cycles after the start pulse.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      stub_cnt <= '0;
      stub_res <= 1'b0;
      stub_c   <= '0;
    end else if (sa_valid && stub_en) begin
      stub_cnt <= 3'd5;
      stub_res <= 1'b0;
      stub_c   <= matmul(sa_a, sa_b);
    end else begin
      stub_res <= (stub_cnt == 3'd2);
      if (stub_cnt != 0) stub_cnt <= stub_cnt - 1'b1;
    end
  end

  assign sa_res = stub_res | force_pulse;
  assign sa_c   = force_pulse ? junk_c : stub_c;

  task automatic check(input string tag, input logic [CW+7:0] obs, input logic [CW+7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    force_pulse = 1'b0;
    stub_en = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    for (int k = 0; k < budget && rsp_valid == '0; k++) next_cycle();
  endtask

  initial begin
    junk_c = fill32(99);

    // Reset state, both while held and for 10 idle cycles after release
    repeat (2) @(negedge clk);
    #1;
    check("reset_held", {busy, req_ready, rsp_valid, sa_valid, rsp_err, owner, sa_a, sa_b}, '0);
    arst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("reset_idle_ctl", {busy, req_ready, rsp_valid, sa_valid, rsp_err, owner, sa_a, sa_b}, '0);
      check("reset_idle_c", rsp_c, '0);
    end

    // Single job from requester 0: identity x all-2s
    @(negedge clk);
    req_a[EW-1:0] = ident8(1);
    req_b[EW-1:0] = fill8(2);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    check("c0_req_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("c1_start", {sa_valid, busy, owner}, 3'b110);
    check("c1_sa_a", sa_a, ident8(1));
    check("c1_sa_b", sa_b, fill8(2));
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      check("c2_6_quiet", {sa_valid, rsp_valid}, 3'b000);
    end
    next_cycle();
    check("c7_rsp_valid", {rsp_valid, rsp_err}, 3'b010);
    check("c7_rsp_c", rsp_c, fill32(2));
    $display("[TB] job owner=0 C[0]=%0d", rsp_c[31:0]);
    next_cycle();
    check("c8_idle", {busy, rsp_valid}, 3'b000);

    // Both requesters continuously valid: grants alternate 0,1,0,1
    do_reset();
    req_a = {fill8(1), ident8(1)};
    req_b = {fill8(3), fill8(2)};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 20 && req_ready == '0; k++) next_cycle();
      check("rr_grant", req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
      wait_rsp(20);
      check("rr_rsp_valid", {rsp_valid, owner}, (j % 2 == 0) ? 3'b010 : 3'b101);
      check("rr_rsp_c", rsp_c, (j % 2 == 0) ? fill32(2) : fill32(12));
      $display("[TB] job owner=%0d C[0]=%0d", owner, rsp_c[31:0]);
      next_cycle();
    end

    // Requester 1 stalls its response; requester 0 waits until after the handshake
    do_reset();
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    #1;
    check("stall_grant1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    check("stall_busy_no_ready", req_ready, 2'b00);
    wait_rsp(12);
    for (int i = 0; i < 20; i++) begin
      check("stall_hold", {rsp_valid, req_ready, rsp_c}, {2'b10, 2'b00, fill32(12)});
      next_cycle();
    end
    $display("[TB] job owner=1 C[0]=%0d (after stall)", rsp_c[31:0]);
    @(negedge clk);
    rsp_ready = 2'b10;
    #1;
    check("stall_hs_no_ready", req_ready, 2'b00);
    @(negedge clk);
    rsp_ready = 2'b11;
    #1;
    check("stall_next_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    wait_rsp(12);
    check("after_stall_rsp", {rsp_valid, rsp_c}, {2'b01, fill32(2)});
    $display("[TB] job owner=0 C[0]=%0d", rsp_c[31:0]);
    next_cycle();

    // Stray result pulse while idle is ignored
    check("stray_pre_idle", busy, 1'b0);
    @(negedge clk);
    force_pulse = 1'b1;
    @(negedge clk);
    force_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("stray_ignored", {busy, rsp_valid, rsp_c}, {1'b0, 2'b00, fill32(2)});
    end

    // Array never answers
    do_reset();
    stub_en = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
`ifdef SYSTOLIC_ARB_WATCHDOG_EN
    #1;
    wait_rsp(40);
    check("wd_rsp", {rsp_valid, rsp_err}, 3'b011);
    check("wd_rsp_c", rsp_c, '0);
    rsp_ready = 2'b01;
    next_cycle();
    check("wd_hs_idle", busy, 1'b0);
`else
    repeat (60) @(negedge clk);
    #1;
    check("no_wd_stuck", {busy, rsp_valid, rsp_err}, 4'b1000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
